cic_comb_chain: RTL

//  Multi-stage, multi-channel CIC comb section. Runs at the decimated rate, after the integrators and decimator.

---
 rtl/cic_pkg.sv | 17 +
 rtl/cic_comb_stage.sv | 57 +++++
 rtl/cic_comb_chain.sv | 106 ++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared CIC width type, parameter defaults and counter-width helper
package cic_pkg;

  typedef int cic_width_t;

  // Defaults shared with the integrator and decimator blocks.
  localparam cic_width_t CIC_NUM_CHAN   = 2;
  localparam cic_width_t CIC_NUM_STAGES = 4;
  localparam cic_width_t CIC_DIFF_DELAY = 1;
  localparam cic_width_t CIC_IN_WIDTH   = 24;
  localparam cic_width_t CIC_OUT_WIDTH  = 16;

  function automatic cic_width_t cic_cnt_width(input cic_width_t max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one comb stage y[n] = x[n] - x[n-DIFF_DELAY] across all channels
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter cic_width_t NUM_CHAN   = CIC_NUM_CHAN,
  parameter cic_width_t WIDTH      = CIC_IN_WIDTH,
  parameter cic_width_t DIFF_DELAY = CIC_DIFF_DELAY
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NUM_CHAN*WIDTH-1:0] i_data,
  input  logic                      i_valid,
  output logic [NUM_CHAN*WIDTH-1:0] o_data,
  output logic                      o_valid
);

  localparam int BUS_W = NUM_CHAN * WIDTH;

  logic [BUS_W-1:0] dly_q [DIFF_DELAY];
  logic [BUS_W-1:0] dly_d [DIFF_DELAY];
  logic [BUS_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // History only advances on a strobe, so input gaps do not disturb the recurrence.
  always_comb begin
    dly_d   = dly_q;
    data_d  = data_q;
    valid_d = i_valid;
    if (i_valid) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        data_d[c*WIDTH +: WIDTH] = i_data[c*WIDTH +: WIDTH] - dly_q[DIFF_DELAY-1][c*WIDTH +: WIDTH];
      end
      dly_d[0] = i_data;
      for (int k = 1; k < DIFF_DELAY; k++) begin
        dly_d[k] = dly_q[k-1];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < DIFF_DELAY; k++) begin
        dly_q[k] <= '0;
      end
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dly_q   <= dly_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;

endmodule

// File: rtl/cic_comb_chain.sv
// rtl/cic_comb_chain.sv - cascaded CIC comb stages with prune register and priming flag; CIC_COMB_CHAIN_ROUND_EN enables round-half-up
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter cic_width_t NUM_CHAN   = CIC_NUM_CHAN,
  parameter cic_width_t NUM_STAGES = CIC_NUM_STAGES,
  parameter cic_width_t DIFF_DELAY = CIC_DIFF_DELAY,
  parameter cic_width_t IN_WIDTH   = CIC_IN_WIDTH,
  parameter cic_width_t OUT_WIDTH  = CIC_OUT_WIDTH
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NUM_CHAN*IN_WIDTH-1:0]  i_data,
  input  logic                          i_valid,
  output logic [NUM_CHAN*OUT_WIDTH-1:0] o_data,
  output logic                          o_valid,
  output logic                          o_primed
);

  localparam int               PRIME_CNT = NUM_STAGES * DIFF_DELAY;
  localparam int               CNT_W     = cic_cnt_width(PRIME_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRIME_CNT);
  localparam int               DROP      = IN_WIDTH - OUT_WIDTH;
  localparam int               RND_SH    = (DROP > 0) ? DROP - 1 : 0;

  logic [NUM_CHAN*IN_WIDTH-1:0] stage_data  [NUM_STAGES+1];
  logic                         stage_valid [NUM_STAGES+1];

  assign stage_data[0]  = i_data;
  assign stage_valid[0] = i_valid;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    cic_comb_stage #(
      .NUM_CHAN   (NUM_CHAN),
      .WIDTH      (IN_WIDTH),
      .DIFF_DELAY (DIFF_DELAY)
    ) u_stage (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_data  (stage_data[s]),
      .i_valid (stage_valid[s]),
      .o_data  (stage_data[s+1]),
      .o_valid (stage_valid[s+1])
    );
  end

  function automatic logic [OUT_WIDTH-1:0] prune(input logic [IN_WIDTH-1:0] x);
`ifdef CIC_COMB_CHAIN_ROUND_EN
    logic [IN_WIDTH:0] sum;
    sum = {x[IN_WIDTH-1], x} + ({{IN_WIDTH{1'b0}}, 1'b1} << RND_SH);
    if (DROP == 0) return x[IN_WIDTH-1 -: OUT_WIDTH];
    // Only a positive value can overflow when adding the half-LSB.
    if (sum[IN_WIDTH] != sum[IN_WIDTH-1]) return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    return sum[IN_WIDTH-1 -: OUT_WIDTH];
`else
    return x[IN_WIDTH-1 -: OUT_WIDTH];
`endif
  endfunction

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]         pflag_q, pflag_d;
  logic [NUM_CHAN*OUT_WIDTH-1:0] o_data_q, o_data_d;
  logic                          o_valid_q, o_valid_d;
  logic                          o_primed_q, o_primed_d;

  // The primed flag rides a shift register in lockstep with the stage valid pipeline.
  always_comb begin
    cnt_d      = cnt_q;
    pflag_d    = '0;
    o_data_d   = o_data_q;
    o_valid_d  = stage_valid[NUM_STAGES];
    o_primed_d = o_primed_q;
    if (i_valid && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    pflag_d[0] = i_valid && (cnt_q == CNT_MAX);
    for (int j = 1; j < NUM_STAGES; j++) begin
      pflag_d[j] = pflag_q[j-1];
    end
    if (stage_valid[NUM_STAGES]) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        o_data_d[c*OUT_WIDTH +: OUT_WIDTH] = prune(stage_data[NUM_STAGES][c*IN_WIDTH +: IN_WIDTH]);
      end
      o_primed_d = o_primed_q | pflag_q[NUM_STAGES-1];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q      <= '0;
      pflag_q    <= '0;
      o_data_q   <= '0;
      o_valid_q  <= 1'b0;
      o_primed_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pflag_q    <= pflag_d;
      o_data_q   <= o_data_d;
      o_valid_q  <= o_valid_d;
      o_primed_q <= o_primed_d;
    end
  end

  assign o_data   = o_data_q;
  assign o_valid  = o_valid_q;
  assign o_primed = o_primed_q;

endmodule
